// File: rtl/adc_bus_pkg.sv
// adc_bus_pkg: shared types and defaults for the ADC bus responder
// Contents: responder state enum, default data width, default conversion
// length and the width of the completed-read counter.
package adc_bus_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, READY, DRIVE} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CONV_CYCLES = 16;
  localparam int CNT_W = 16;
endpackage

// File: rtl/adc_bus_responder_bus_sync.sv
// bus_sync: multi-flop synchronizer for an async active-low strobe
// Ports: clk, rst_n (async, active-low), d (async input), q (synced output).
// Flops reset to 1 so an idle (high) strobe never looks like a falling edge.
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '1;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/adc_bus_responder.sv
// adc_bus_responder: emulated parallel-bus ADC (start strobe, fixed conversion, interrupt, read)
// Ports: clk, rst_n (async, active-low); bus_cs_n/bus_wr_n/bus_rd_n async strobes;
// bus_data_o/bus_data_oe result and pad enable; bus_int_n conversion done (active-low);
// sample_data source sample; overrun_clr/overrun sticky overrun flag; conv_count completed reads.
// Build option: ADC_RESP_RAMP_EN replaces sample_data with an internal wrapping ramp.
module adc_bus_responder
  import adc_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_cs_n,
  input  logic              bus_wr_n,
  input  logic              bus_rd_n,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_data_oe,
  output logic              bus_int_n,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              overrun_clr,
  output logic              overrun,
  output logic [CNT_W-1:0]  conv_count
);
  logic cs_sync, wr_sync, rd_sync, wr_d, start, rd_act;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, count_d;
  logic [DATA_W-1:0] hold_q, hold_d, data_d, src;
  logic oe_d, int_d, ovr_d;
  bus_sync #(.STAGES(SYNC_STAGES)) u_cs (.clk(clk), .rst_n(rst_n), .d(bus_cs_n), .q(cs_sync));
  bus_sync #(.STAGES(SYNC_STAGES)) u_wr (.clk(clk), .rst_n(rst_n), .d(bus_wr_n), .q(wr_sync));
  bus_sync #(.STAGES(SYNC_STAGES)) u_rd (.clk(clk), .rst_n(rst_n), .d(bus_rd_n), .q(rd_sync));
  assign start = wr_d & ~wr_sync & ~cs_sync;
  assign rd_act = ~rd_sync & ~cs_sync;
`ifdef ADC_RESP_RAMP_EN
  logic [DATA_W-1:0] ramp_q;
  assign src = ramp_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ramp_q <= '0;
    else if (start && state_q != DRIVE) ramp_q <= ramp_q + 1'b1;
`else
  assign src = sample_data;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hold_q <= '0;
      wr_d <= 1'b1;
      bus_data_o <= '0;
      bus_data_oe <= 1'b0;
      bus_int_n <= 1'b1;
      overrun <= 1'b0;
      conv_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      wr_d <= wr_sync;
      bus_data_o <= data_d;
      bus_data_oe <= oe_d;
      bus_int_n <= int_d;
      overrun <= ovr_d;
      conv_count <= count_d;
    end
  // A start outside DRIVE always (re)starts the conversion; a start that
  // interrupts CONVERT or READY flags overrun, which beats a same-cycle clear.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    data_d = bus_data_o;
    oe_d = bus_data_oe;
    int_d = bus_int_n;
    count_d = conv_count;
    ovr_d = overrun_clr ? 1'b0 : overrun;
    if (start && state_q != DRIVE) begin
      state_d = CONVERT;
      cnt_d = CNT_W'(CONV_CYCLES - 1);
      hold_d = src;
      int_d = 1'b1;
      ovr_d = (state_q != IDLE) | ovr_d;
    end else begin
      case (state_q)
        CONVERT: begin
          state_d = cnt_q == '0 ? READY : CONVERT;
          int_d = cnt_q != '0;
          cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        end
        READY: if (rd_act) begin
          state_d = DRIVE;
          data_d = hold_q;
          oe_d = 1'b1;
        end
        DRIVE: if (!rd_act) begin
          state_d = IDLE;
          oe_d = 1'b0;
          int_d = 1'b1;
          count_d = conv_count + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_bus_responder.sv
// tb_adc_bus_responder: directed scoreboard bench for adc_bus_responder
// Stimulus pushes each expected read value into a queue; a monitor pops and
// compares whenever bus_data_oe rises. Status outputs are checked inline.
module tb_adc_bus_responder;
  logic clk = 0, rst_n = 0;
  logic bus_cs_n = 1, bus_wr_n = 1, bus_rd_n = 1, overrun_clr = 0;
  logic [7:0] sample_data = 0, bus_data_o;
  logic bus_data_oe, bus_int_n, overrun, oe_prev = 0;
  logic [15:0] conv_count;
  logic [7:0] exp_q[$];
  int errors = 0, checks = 0;

  adc_bus_responder dut (
    .clk(clk), .rst_n(rst_n), .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n),
    .bus_rd_n(bus_rd_n), .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe),
    .bus_int_n(bus_int_n), .sample_data(sample_data), .overrun_clr(overrun_clr),
    .overrun(overrun), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    oe_prev <= bus_data_oe;
    if (bus_data_oe && !oe_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got data %0h with no read pending", bus_data_o);
      end else chk("read_data", bus_data_o, exp_q.pop_front());
    end
  end

  task automatic start_conv();
    @(posedge clk);
    #1 bus_cs_n = 0; bus_wr_n = 0;
    repeat (4) @(posedge clk);
    #1 bus_wr_n = 1;
  endtask

  task automatic wait_int();
    for (int i = 0; i < 40 && bus_int_n; i++) @(negedge clk);
    chk("int_wait", bus_int_n, 0);
  endtask

  task automatic do_read(input logic [7:0] exp);
    exp_q.push_back(exp);
    @(posedge clk);
    #1 bus_rd_n = 0;
    for (int i = 0; i < 10 && !bus_data_oe; i++) @(negedge clk);
    chk("oe_up", bus_data_oe, 1);
    repeat (3) @(posedge clk);
    #1 bus_rd_n = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_oe", bus_data_oe, 0);
    chk("rst_int", bus_int_n, 1);
    chk("rst_ovr", overrun, 0);
    chk("rst_count", conv_count, 0);
    chk("rst_data", bus_data_o, 0);
    #1 rst_n = 1;
`ifdef ADC_RESP_RAMP_EN
    for (int i = 0; i < 257; i++) begin
      start_conv();
      wait_int();
      do_read(i[7:0]);
    end
    chk("ramp_count", conv_count, 257);
`else
    sample_data = 8'hA5;
    @(posedge clk);
    #1 bus_cs_n = 0; bus_wr_n = 0;
    repeat (4) @(posedge clk);
    #1 bus_wr_n = 1;
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("int_not_yet", bus_int_n, 1);
    @(posedge clk);
    @(negedge clk);
    chk("int_on_time", bus_int_n, 0);
    chk("oe_ready", bus_data_oe, 0);
    do_read(8'hA5);
    chk("basic_oe_off", bus_data_oe, 0);
    chk("basic_int_off", bus_int_n, 1);
    chk("basic_count", conv_count, 1);
    chk("basic_data_kept", bus_data_o, 8'hA5);

    sample_data = 8'h11;
    start_conv();
    wait_int();
    sample_data = 8'h3C;
    start_conv();
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_int_high", bus_int_n, 1);
    wait_int();
    do_read(8'h3C);
    chk("ovr_count", conv_count, 2);

    @(posedge clk);
    #1 overrun_clr = 1;
    @(posedge clk);
    #1 overrun_clr = 0;
    @(negedge clk);
    chk("ovr_clear", overrun, 0);
    sample_data = 8'h5A;
    start_conv();
    repeat (3) @(posedge clk);
    sample_data = 8'h66;
    @(posedge clk);
    #1 bus_wr_n = 0;
    repeat (2) @(posedge clk);
    #1 overrun_clr = 1;
    @(posedge clk);
    #1 overrun_clr = 0;
    @(posedge clk);
    #1 bus_wr_n = 1;
    @(negedge clk);
    chk("ovr_set_wins", overrun, 1);
    @(posedge clk);
    #1 overrun_clr = 1;
    @(posedge clk);
    #1 overrun_clr = 0;
    @(negedge clk);
    chk("ovr_clear2", overrun, 0);
    wait_int();
    do_read(8'h66);
    chk("clr_count", conv_count, 3);

    sample_data = 8'hC3;
    start_conv();
    sample_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 bus_rd_n = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("early_oe", bus_data_oe, 0);
    chk("early_int", bus_int_n, 1);
    #1 bus_rd_n = 1;
    wait_int();
    do_read(8'hC3);
    chk("early_ovr", overrun, 0);
    chk("early_count", conv_count, 4);

    sample_data = 8'h77;
    start_conv();
    wait_int();
    exp_q.push_back(8'h77);
    @(posedge clk);
    #1 bus_rd_n = 0;
    for (int i = 0; i < 10 && !bus_data_oe; i++) @(negedge clk);
    chk("drive_oe", bus_data_oe, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_oe", bus_data_oe, 0);
    chk("rst_mid_int", bus_int_n, 1);
    chk("rst_mid_count", conv_count, 0);
    bus_rd_n = 1;
    bus_cs_n = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
`endif
    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adc_bus_responder.md
Name: adc_bus_responder

Overview:
Responder end of the parallel ADC strobe bus (cs_n/wr_n/rd_n/data).
- Emulates a converter: a wr_n strobe starts a conversion, which takes a fixed time; an interrupt reports completion; a rd_n strobe drives the result.
- Used for on-board loopback and bring-up of the acquisition controller before real ADC silicon is attached.
- Sits between a sample source (pattern or captured data) and the bus pins.

Parameters:
DATA_W, 8, bus data width.
CONV_CYCLES, 16, clk cycles from conversion start to completion; legal range 1..65535.
SYNC_STAGES, 2, synchronizer depth for incoming strobes; minimum 2.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, asynchronous, active-low.
bus_cs_n  input  1  chip select from controller, async to clk.
bus_wr_n  input  1  conversion-start strobe, async.
bus_rd_n  input  1  read strobe, async.
bus_data_o  output  DATA_W  result driven toward bus.
bus_data_oe  output  1  pad output enable, 1 = drive.
bus_int_n  output  1  conversion done, active-low.
sample_data  input  DATA_W  source sample, captured at conversion start.
overrun_clr  input  1  single-cycle clear of overrun.
overrun  output  1  sticky: new start before previous result read.
conv_count  output  16  completed-read counter.

Behaviour:
- Reset values: bus_data_o=0, bus_data_oe=0, bus_int_n=1, overrun=0, conv_count=0, state IDLE, hold=0, synchronizer flops=1.
- Strobes pass through SYNC_STAGES flops. Falling-edge detect on synced wr_n: start = wr_fall & ~cs_sync. Read active: rd_act = ~rd_sync & ~cs_sync.
- Pin-to-action latency: SYNC_STAGES+1 cycles.
- States: IDLE, CONVERT, READY, DRIVE.
- IDLE: on start -> hold<=sample_data, counter<=CONV_CYCLES-1, go to CONVERT.
- CONVERT: counter decrements each cycle. When counter is 0 -> READY, bus_int_n<=0. With CONV_CYCLES=1, READY is reached the cycle after CONVERT entry.
- READY: on rd_act -> DRIVE, bus_data_o<=hold, bus_data_oe<=1.
- DRIVE: outputs held while rd_act. When rd_act drops (rd_n or cs_n high) -> bus_data_oe<=0, bus_int_n<=1, conv_count<=conv_count+1 (wraps at 16 bits), return to IDLE. bus_data_o retains its last value.
- start in CONVERT: overrun<=1, restart with new hold and reloaded counter.
- start in READY: overrun<=1, bus_int_n<=1, unread result discarded, restart as from IDLE.
- start in DRIVE: ignored; no overrun.
- rd_act in IDLE or CONVERT: ignored; bus_data_oe stays 0.
- start and rd_act in the same cycle in READY: start wins (overrun path).
- overrun_clr and an overrun set in the same cycle: set wins.
- cs_n high mid-conversion: conversion continues; only the strobes are gated.
- rst_n asserted mid-operation: immediate return to reset values; bus_data_oe drops asynchronously.

Optional Feature:
ADC_RESP_RAMP_EN:
- Defined: sample_data is ignored. hold<=ramp at each accepted start, then ramp increments (starts at 0, wraps at 2^DATA_W). ramp resets to 0.
- Undefined: hold captures sample_data; no ramp register exists.

Decomposition:
- Package adc_bus_pkg: state enum (IDLE/CONVERT/READY/DRIVE), default DATA_W, CONV_CYCLES, and the conv_count width of 16.
- One sub-module, bus_sync: SYNC_STAGES-deep synchronizer with reset value 1, instantiated per strobe.

Test Plan:
- Basic read, CONV_CYCLES=16, sample_data=0xA5: wr_n low 4 cycles with cs_n low -> bus_int_n low 16 cycles after start detect. rd_n low -> bus_data_o=0xA5, bus_data_oe=1. rd_n release -> oe=0, int_n=1, conv_count=1.
- Overrun: second wr_n strobe while READY with sample_data=0x3C -> overrun=1, int_n returns to 1. After the new conversion, read returns 0x3C.
- Overrun clear: pulse overrun_clr in the same cycle as a new overrun event -> overrun stays 1. Pulse it alone next cycle -> overrun=0.
- Premature read: rd_n low during CONVERT -> bus_data_oe stays 0 and state is unchanged; the read after completion returns the captured value.
- Reset mid-DRIVE: assert rst_n while bus_data_oe=1 -> oe=0 and int_n=1 immediately; conv_count=0.
- ADC_RESP_RAMP_EN defined, DATA_W=8: 257 start/read cycles -> data sequence 0x00..0xFF, then 0x00; conv_count=257.
